// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the wait-state memory controller.
//   - mem_ctrl bit positions (LOAD_ADDR, WRITE, READ, FETCH)
//   - controller FSM state and access-kind enums
//   - count_width(): wait counter width for a given maximum count
package mem_ctrl_pkg;

  localparam int unsigned LOAD_ADDR = 0;
  localparam int unsigned WRITE     = 1;
  localparam int unsigned READ      = 2;
  localparam int unsigned FETCH     = 3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    RD,
    WR,
    FE
  } access_kind_t;

  // A zero-wait build still needs a 1-bit counter to stay legal.
  function automatic int unsigned count_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter used to stretch a memory access by wait states.
// Ports:
//   clock      in   falling-edge clock
//   reset      in   synchronous active-high reset
//   load       in   load load_value (has priority over dec)
//   load_value in   WIDTH-bit start value
//   dec        in   decrement by one, saturating at zero
//   done       out  count is zero
module mem_wait_counter #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(negedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/mem_controller_ws.sv
// Bridges the shared CPU data bus to a synchronous memory port with a
// configurable number of wait states per access. Performs data reads,
// data writes and instruction fetches; traps out-of-range addresses.
// All registers update on the falling edge of clock.
// Optional build macro: ADDR_AUTOINC_EN -- after each completed in-range
// fetch, addr advances by 1 (or 2 when the fetched word has bit[1] set).
// Ports:
//   clock, reset         falling-edge clock, synchronous active-high reset
//   bus_in               shared bus value (address or write data)
//   bus_out, bus_oe      read data and its drive enable (DONE of a read)
//   mem_ctrl             [0] load_addr, [1] write, [2] read, [3] fetch
//   mem_addr, mem_wdata  memory address / write data
//   mem_rdata            memory read data, valid on the final wait cycle
//   mem_we, mem_re       memory write / read strobes
//   busy                 access in progress
//   instruction          last fetched word; double_increment = bit[1]
//   fault                sticky out-of-range flag
//   cmd_dropped          pulse when a command arrives during ACCESS
module mem_controller_ws
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 15,
  parameter int unsigned MEM_DEPTH   = 32768,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  input  logic [3:0]        mem_ctrl,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic              mem_re,
  output logic              busy,
  output logic [DATA_W-1:0] instruction,
  output logic              double_increment,
  output logic              fault,
  output logic              cmd_dropped
);

  localparam int unsigned CW = count_width(WAIT_STATES);

  state_t       state, state_next;
  access_kind_t kind, req;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_of_range;
  logic              cnt_load, cnt_dec, cnt_done;
`ifdef ADDR_AUTOINC_EN
  logic              inc_pending;
`endif

  mem_wait_counter #(
    .WIDTH (CW)
  ) u_wait (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (CW'(WAIT_STATES)),
    .dec        (cnt_dec),
    .done       (cnt_done)
  );

  // Highest-priority requested access; the rest are discarded.
  always_comb begin
    req = NONE;
    if (mem_ctrl[FETCH])      req = FE;
    else if (mem_ctrl[READ])  req = RD;
    else if (mem_ctrl[WRITE]) req = WR;
  end

  // Range check uses the address held before any same-edge load.
  assign out_of_range = (64'(addr) >= 64'(MEM_DEPTH));

  always_ff @(negedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // DONE accepts commands exactly like IDLE.
  always_comb begin
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (req != NONE) begin
          state_next = out_of_range ? DONE : ACCESS;
          cnt_load   = 1'b1;
        end
      end
      ACCESS: begin
        cnt_dec = 1'b1;
        if (cnt_done) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      addr        <= '0;
      acc_addr    <= '0;
      kind        <= NONE;
      mem_wdata   <= '0;
      rd_data     <= '0;
      instruction <= '0;
      fault       <= 1'b0;
      cmd_dropped <= 1'b0;
`ifdef ADDR_AUTOINC_EN
      inc_pending <= 1'b0;
`endif
    end else begin
      cmd_dropped <= (state == ACCESS) && (mem_ctrl != 4'b0000);
`ifdef ADDR_AUTOINC_EN
      inc_pending <= 1'b0;
`endif
      if (state != ACCESS) begin
        if (mem_ctrl[LOAD_ADDR]) addr <= bus_in[ADDR_W-1:0];
`ifdef ADDR_AUTOINC_EN
        // Increment is applied on the edge leaving DONE so a load there wins.
        else if (inc_pending)
          addr <= addr + (instruction[1] ? ADDR_W'(2) : ADDR_W'(1));
`endif
        if (req != NONE) begin
          kind     <= req;
          acc_addr <= addr;
          if (req == WR) mem_wdata <= bus_in;
          if (out_of_range) begin
            fault <= 1'b1;
            if (req == RD) rd_data <= '0;
            if (req == FE) instruction <= '0;
          end
        end
      end else if (cnt_done) begin
        case (kind)
          FE: begin
            instruction <= mem_rdata;
`ifdef ADDR_AUTOINC_EN
            inc_pending <= 1'b1;
`endif
          end
          RD:      rd_data <= mem_rdata;
          default: ;
        endcase
      end
    end
  end

  assign busy             = (state != IDLE);
  assign mem_we           = (state == ACCESS) && (kind == WR);
  assign mem_re           = (state == ACCESS) && ((kind == RD) || (kind == FE));
  assign bus_oe           = (state == DONE) && (kind == RD);
  assign bus_out          = bus_oe ? rd_data : '0;
  assign mem_addr         = acc_addr;
  assign double_increment = instruction[1];

endmodule

// File: tb/tb_mem_controller_ws.sv
// Randomised bench for mem_controller_ws with a transaction-level model.
module tb_mem_controller_ws;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 15;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WS = 3;

  logic          clock, reset;
  logic [DW-1:0] bus_in, bus_out, mem_wdata, mem_rdata, instruction;
  logic          bus_oe, mem_we, mem_re, busy, double_increment, fault, cmd_dropped;
  logic [3:0]    mem_ctrl;
  logic [AW-1:0] mem_addr;

  mem_controller_ws #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .MEM_DEPTH   (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .bus_in           (bus_in),
    .bus_out          (bus_out),
    .bus_oe           (bus_oe),
    .mem_ctrl         (mem_ctrl),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_rdata        (mem_rdata),
    .mem_we           (mem_we),
    .mem_re           (mem_re),
    .busy             (busy),
    .instruction      (instruction),
    .double_increment (double_increment),
    .fault            (fault),
    .cmd_dropped      (cmd_dropped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Physical memory the DUT talks to.
  logic [DW-1:0] seed_mem [DEPTH];
  logic [DW-1:0] ram      [DEPTH];
  logic          tb_fill;

  always @(negedge clock) begin
    if (tb_fill) begin
      for (int i = 0; i < int'(DEPTH); i++) ram[i] <= seed_mem[i];
    end else if (mem_we) begin
      ram[mem_addr[9:0]] <= mem_wdata;
    end
  end

  assign mem_rdata = ram[mem_addr[9:0]];

  // Reference model state.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_instr;
  logic          m_fault;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_addr  = '0;
    m_instr = '0;
    m_fault = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy",   32'(busy), 0);
    check("rst_re",     32'(mem_re), 0);
    check("rst_we",     32'(mem_we), 0);
    check("rst_oe",     32'(bus_oe), 0);
    check("rst_bus",    32'(bus_out), 0);
    check("rst_instr",  32'(instruction), 0);
    check("rst_fault",  32'(fault), 0);
    check("rst_drop",   32'(cmd_dropped), 0);
    check("rst_addr",   32'(mem_addr), 0);
    check("rst_wdata",  32'(mem_wdata), 0);
  endtask

  // Issues one command from idle and checks the whole transaction.
  task automatic run_txn(input logic [3:0] ctrl, input logic [DW-1:0] b, input bit noise);
    int            kind;
    logic [AW-1:0] acc;
    bit            oor, noise_on;
    int            exp_busy, exp_re, exp_we, exp_oe;
    logic [DW-1:0] exp_bus, got_bus;
    int            n_busy, n_re, n_we, n_both, n_badaddr, n_badw, n_oe, n_drop, cyc;

    kind = ctrl[3] ? 3 : ctrl[2] ? 2 : ctrl[1] ? 1 : 0;
    acc  = m_addr;
    if (ctrl[0]) m_addr = b[AW-1:0];
    oor      = (kind != 0) && (32'(acc) >= DEPTH);
    exp_busy = (kind == 0) ? 0 : oor ? 1 : int'(WS) + 2;
    exp_re   = (!oor && (kind == 3 || kind == 2)) ? int'(WS) + 1 : 0;
    exp_we   = (!oor && kind == 1) ? int'(WS) + 1 : 0;
    exp_oe   = (kind == 2) ? 1 : 0;
    exp_bus  = oor ? '0 : ref_mem[acc[9:0]];
    if (kind != 0 && oor) m_fault = 1'b1;
    if (kind == 3) begin
      m_instr = oor ? '0 : ref_mem[acc[9:0]];
`ifdef ADDR_AUTOINC_EN
      if (!oor) m_addr = m_addr + (m_instr[1] ? AW'(2) : AW'(1));
`endif
    end
    if (kind == 1 && !oor) ref_mem[acc[9:0]] = b;
    noise_on = noise && (kind != 0) && !oor;

    mem_ctrl = ctrl;
    bus_in   = b;
    @(posedge clock);
    mem_ctrl = 4'b0000;
    bus_in   = DW'($urandom);
    n_busy = 0; n_re = 0; n_we = 0; n_both = 0; n_badaddr = 0;
    n_badw = 0; n_oe = 0; n_drop = 0; cyc = 0; got_bus = '0;
    while (busy && cyc < 40) begin
      n_busy++;
      if (mem_re) n_re++;
      if (mem_we) n_we++;
      if (mem_re && mem_we) n_both++;
      if ((mem_re || mem_we) && mem_addr !== acc) n_badaddr++;
      if (mem_we && mem_wdata !== b) n_badw++;
      if (bus_oe) begin
        n_oe++;
        got_bus = bus_out;
      end
      if (cmd_dropped) n_drop++;
      mem_ctrl = (noise_on && cyc == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      @(posedge clock);
      cyc++;
    end
    if (cmd_dropped) n_drop++;

    check("busy_cycles", 32'(n_busy), 32'(exp_busy));
    check("re_cycles",   32'(n_re), 32'(exp_re));
    check("we_cycles",   32'(n_we), 32'(exp_we));
    check("strobe_both", 32'(n_both), 0);
    check("strobe_addr", 32'(n_badaddr), 0);
    check("write_data",  32'(n_badw), 0);
    check("oe_cycles",   32'(n_oe), 32'(exp_oe));
    if (exp_oe != 0) check("read_data", 32'(got_bus), 32'(exp_bus));
    check("dropped",     32'(n_drop), noise_on ? 1 : 0);
    check("instruction", 32'(instruction), 32'(m_instr));
    check("double_inc",  32'(double_increment), 32'(m_instr[1]));
    check("fault",       32'(fault), 32'(m_fault));
  endtask

  initial begin
    logic [3:0]    c;
    logic [DW-1:0] b;

    for (int i = 0; i < int'(DEPTH); i++) begin
      seed_mem[i] = DW'($urandom);
      ref_mem[i]  = seed_mem[i];
    end
    reset    = 1'b1;
    tb_fill  = 1'b1;
    mem_ctrl = 4'b0000;
    bus_in   = '0;
    repeat (2) @(posedge clock);
    reset   = 1'b0;
    tb_fill = 1'b0;
    model_reset();
    check_reset_outputs();

    // Write then read back at 0x0012.
    run_txn(4'b0001, 16'h0012, 1'b0);
    run_txn(4'b0010, 16'hBEEF, 1'b0);
    run_txn(4'b0100, 16'h0000, 1'b1);

    // Fetch of a word with bit[1] set.
    run_txn(4'b0001, 16'h0020, 1'b0);
    run_txn(4'b0010, 16'h0002, 1'b0);
    run_txn(4'b0001, 16'h0020, 1'b0);
    run_txn(4'b1000, 16'h0000, 1'b0);

    // All three access bits together: fetch wins, write discarded.
    run_txn(4'b0001, 16'h0030, 1'b0);
    run_txn(4'b1110, 16'h1234, 1'b0);

    // Random traffic, mostly in range.
    for (int t = 0; t < 80; t++) begin
      c = 4'($urandom_range(0, 15));
      b = DW'($urandom);
      if ($urandom_range(0, 7) != 0) b[14:10] = 5'b0;
      run_txn(c, b, 1'($urandom_range(0, 1)));
    end

    // Out of range read, then sticky fault across in-range accesses.
    run_txn(4'b0001, 16'h0400, 1'b0);
    run_txn(4'b0100, 16'h0000, 1'b0);
    run_txn(4'b1000, 16'h0000, 1'b0);
    run_txn(4'b0001, 16'h0012, 1'b0);
    run_txn(4'b0100, 16'h0000, 1'b0);

    // Reset in the middle of a read.
    mem_ctrl = 4'b0100;
    @(posedge clock);
    mem_ctrl = 4'b0000;
    check("pre_reset_re", 32'(mem_re), 1);
    reset = 1'b1;
    @(posedge clock);
    reset = 1'b0;
    model_reset();
    check_reset_outputs();

    // Recovery after reset.
    run_txn(4'b0001, 16'h0012, 1'b0);
    run_txn(4'b0100, 16'h0000, 1'b0);
    run_txn(4'b0011, 16'h0055, 1'b0);
    run_txn(4'b0100, 16'h0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
